cal_cost_tracker: RTL and testbench



---
 rtl/cal_cost_tracker_if.sv | 27 ++
 rtl/cal_cost_tracker.sv | 150 +++++++++++++++
 tb/tb_cal_cost_tracker.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cal_cost_tracker_if.sv
// Term input and result bus between the permutation generator, the cost tracker
// and the result interface.
interface cal_cost_tracker_if #(
   parameter int unsigned COST_W = 7,
   parameter int unsigned SUM_W  = 10,
   parameter int unsigned CNT_W  = 4
);
   logic              clear;
   logic              start;
   logic [COST_W-1:0] Cost;
   logic              busy;
   logic [SUM_W-1:0]  MinCost;
   logic [CNT_W-1:0]  MatchCount;
   logic [SUM_W-1:0]  LastSum;
   logic              sat;
   logic              done;

   modport master (
      output clear, start, Cost,
      input  busy, MinCost, MatchCount, LastSum, sat, done
   );

   modport slave (
      input  clear, start, Cost,
      output busy, MinCost, MatchCount, LastSum, sat, done
   );
endinterface

// File: rtl/cal_cost_tracker.sv
// Accumulates TERMS cost terms per candidate and tracks the minimum candidate
// total and how many candidates reached it.
module cal_cost_tracker #(
   parameter int unsigned COST_W = 7,
   parameter int unsigned TERMS  = 8,
   parameter int unsigned SUM_W  = 10,
   parameter int unsigned CNT_W  = 4
) (
   input  logic              CLK,
   input  logic              RST,
   cal_cost_tracker_if.slave bus
);
   localparam int unsigned CNT_TW = $clog2(TERMS + 1);
   localparam int unsigned ADD_W  = ((COST_W > SUM_W) ? COST_W : SUM_W) + 1;

   localparam logic [SUM_W-1:0]  SUM_MAX = '1;
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;
   localparam logic [CNT_TW-1:0] TERMS_C = CNT_TW'(TERMS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      CMP  = 2'd2
   } state_t;

   state_t            state_q,  state_d;
   logic [CNT_TW-1:0] cnt_q,    cnt_d;
   logic [SUM_W-1:0]  acc_q,    acc_d;
   logic              ovf_q,    ovf_d;
   logic              first_q,  first_d;
   logic [SUM_W-1:0]  min_q,    min_d;
   logic [CNT_W-1:0]  match_q,  match_d;
   logic [SUM_W-1:0]  last_q,   last_d;
   logic              sat_q,    sat_d;
   logic              done_q,   done_d;
   logic              busy_q,   busy_d;

   logic [ADD_W-1:0]  sum_raw;
   logic              term_ovf;
   logic [SUM_W-1:0]  term_sum;
   logic [CNT_TW-1:0] cnt_inc;

   // Wide add then clamp; acc is zero in IDLE so the first term needs no special path.
   always_comb begin
      sum_raw  = ADD_W'(acc_q) + ADD_W'(bus.Cost);
      term_ovf = (sum_raw > ADD_W'(SUM_MAX));
      term_sum = term_ovf ? SUM_MAX : SUM_W'(sum_raw);
      cnt_inc  = cnt_q + CNT_TW'(1);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      first_d = first_q;
      min_d   = min_q;
      match_d = match_q;
      last_d  = last_q;
      sat_d   = sat_q;
      done_d  = 1'b0;
      busy_d  = 1'b0;

      case (state_q)
         IDLE, ACC: begin
            if (bus.start) begin
               acc_d   = term_sum;
               ovf_d   = ovf_q | term_ovf;
               cnt_d   = cnt_inc;
               state_d = (cnt_inc == TERMS_C) ? CMP : ACC;
            end
         end
         CMP: begin
            last_d = acc_q;
            sat_d  = sat_q | ovf_q;
            done_d = 1'b1;
            // first_q separates a genuine all-ones total from the reset value of min.
            if (!first_q || (acc_q < min_q)) begin
               min_d   = acc_q;
               match_d = CNT_W'(1);
               first_d = 1'b1;
            end else if ((acc_q == min_q) && (match_q != CNT_MAX)) begin
               match_d = match_q + CNT_W'(1);
            end
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = IDLE;
         end
         default: begin
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = IDLE;
         end
      endcase

      // Restart discards any partial candidate and suppresses its done pulse.
      if (bus.clear) begin
         state_d = IDLE;
         cnt_d   = '0;
         acc_d   = '0;
         ovf_d   = 1'b0;
         first_d = 1'b0;
         min_d   = SUM_MAX;
         match_d = '0;
         last_d  = '0;
         sat_d   = 1'b0;
         done_d  = 1'b0;
      end

      busy_d = (state_d == CMP);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         first_q <= 1'b0;
         min_q   <= SUM_MAX;
         match_q <= '0;
         last_q  <= '0;
         sat_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         first_q <= first_d;
         min_q   <= min_d;
         match_q <= match_d;
         last_q  <= last_d;
         sat_q   <= sat_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.busy       = busy_q;
   assign bus.MinCost    = min_q;
   assign bus.MatchCount = match_q;
   assign bus.LastSum    = last_q;
   assign bus.sat        = sat_q;
   assign bus.done       = done_q;

endmodule

// File: tb/tb_cal_cost_tracker.sv
// Bench for cal_cost_tracker: TERMS=8 (SUM_W 10 and 9 side by side) and TERMS=1,
// checked against a candidate-level min/match model.
module tb_cal_cost_tracker;

   typedef struct packed {
      logic [9:0] min;
      logic [3:0] cnt;
      logic [9:0] last;
      logic       sat;
      logic       done;
      logic       busy;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       t8_start, t8_clear;
   logic [6:0] t8_cost;
   logic       t1_start, t1_clear;
   logic [6:0] t1_cost;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   cal_cost_tracker_if #(.COST_W(7), .SUM_W(10), .CNT_W(4)) b8 ();
   cal_cost_tracker_if #(.COST_W(7), .SUM_W(9),  .CNT_W(4)) b9 ();
   cal_cost_tracker_if #(.COST_W(7), .SUM_W(10), .CNT_W(4)) b1 ();

   assign b8.start = t8_start;
   assign b8.clear = t8_clear;
   assign b8.Cost  = t8_cost;
   assign b9.start = t8_start;
   assign b9.clear = t8_clear;
   assign b9.Cost  = t8_cost;
   assign b1.start = t1_start;
   assign b1.clear = t1_clear;
   assign b1.Cost  = t1_cost;

   cal_cost_tracker #(.COST_W(7), .TERMS(8), .SUM_W(10), .CNT_W(4)) dut8 (.CLK(clk), .RST(rst), .bus(b8));
   cal_cost_tracker #(.COST_W(7), .TERMS(8), .SUM_W(9),  .CNT_W(4)) dut9 (.CLK(clk), .RST(rst), .bus(b9));
   cal_cost_tracker #(.COST_W(7), .TERMS(1), .SUM_W(10), .CNT_W(4)) dut1 (.CLK(clk), .RST(rst), .bus(b1));

   // Candidate-level reference: index 0 = TERMS 8/SUM_W 10, 1 = TERMS 8/SUM_W 9, 2 = TERMS 1.
   int m_min[3], m_cnt[3], m_last[3];
   bit m_first[3], m_sat[3];

   function automatic int maxv(input int k);
      return (k == 1) ? 511 : 1023;
   endfunction

   function automatic void m_reset(input int k);
      m_min[k] = maxv(k); m_cnt[k] = 0; m_last[k] = 0; m_sat[k] = 1'b0; m_first[k] = 1'b0;
   endfunction

   function automatic void m_commit(input int k, input int raw);
      int c;
      c = (raw > maxv(k)) ? maxv(k) : raw;
      if (raw > maxv(k)) m_sat[k] = 1'b1;
      m_last[k] = c;
      if (!m_first[k] || c < m_min[k]) begin
         m_min[k] = c; m_cnt[k] = 1; m_first[k] = 1'b1;
      end else if (c == m_min[k] && m_cnt[k] < 15) begin
         m_cnt[k] = m_cnt[k] + 1;
      end
   endfunction

   function automatic obs_t expv(input int k, input bit d, input bit b);
      obs_t e;
      e.min = 10'(m_min[k]); e.cnt = 4'(m_cnt[k]); e.last = 10'(m_last[k]);
      e.sat = m_sat[k]; e.done = d; e.busy = b;
      return e;
   endfunction

   function automatic obs_t obs(input int k);
      obs_t o;
      case (k)
         0: begin o.min = b8.MinCost; o.cnt = b8.MatchCount; o.last = b8.LastSum;
                  o.sat = b8.sat; o.done = b8.done; o.busy = b8.busy; end
         1: begin o.min = 10'(b9.MinCost); o.cnt = b9.MatchCount; o.last = 10'(b9.LastSum);
                  o.sat = b9.sat; o.done = b9.done; o.busy = b9.busy; end
         default: begin o.min = b1.MinCost; o.cnt = b1.MatchCount; o.last = b1.LastSum;
                  o.sat = b1.sat; o.done = b1.done; o.busy = b1.busy; end
      endcase
      return o;
   endfunction

   function automatic string fmt(input obs_t o);
      return $sformatf("min=%0d cnt=%0d last=%0d sat=%0b done=%0b busy=%0b",
                       o.min, o.cnt, o.last, o.sat, o.done, o.busy);
   endfunction

   // Feed one TERMS=8 candidate; capture the CMP cycle, the done cycle and done latency.
   task automatic cand8(input int t[8], input int maxgap, input bit hold,
                        output obs_t oc[2], output obs_t od[2], output int lat);
      for (int i = 0; i < 8; i++) begin
         t8_start = 1'b0;
         repeat ($urandom_range(0, maxgap)) @(negedge clk);
         t8_start = 1'b1;
         t8_cost  = 7'(t[i]);
         @(negedge clk);
      end
      t8_start = hold;
      t8_cost  = hold ? 7'd99 : 7'd0;
      oc[0] = obs(0);
      oc[1] = obs(1);
      lat = 0;
      while (lat < 5) begin
         @(negedge clk);
         lat++;
         if (b8.done) break;
      end
      t8_start = 1'b0;
      od[0] = obs(0);
      od[1] = obs(1);
   endtask

   task automatic clear8();
      t8_clear = 1'b1;
      @(negedge clk);
      t8_clear = 1'b0;
      m_reset(0);
      m_reset(1);
   endtask

   task automatic test_reset();
      obs_t o;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         m_reset(k);
         o = obs(k);
         n_cmp++;
         if (o !== expv(k, 1'b0, 1'b0)) begin
            n_bad++; $display("FAIL reset[%0d] got %s want %s", k, fmt(o), fmt(expv(k, 1'b0, 1'b0)));
         end
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_legacy();
      int costs[8], wmin[8], wcnt[8];
      obs_t o;
      costs = '{50, 45, 40, 35, 30, 50, 30, 30};
      wmin  = '{50, 45, 40, 35, 30, 30, 30, 30};
      wcnt  = '{1, 1, 1, 1, 1, 1, 2, 3};
      for (int i = 0; i < 8; i++) begin
         t1_start = 1'b1;
         t1_cost  = 7'(costs[i]);
         @(negedge clk);
         t1_start = 1'b0;
         o = obs(2);
         n_cmp++;
         if (o !== expv(2, 1'b0, 1'b1)) begin
            n_bad++; $display("FAIL legacy_cmp[%0d] got %s want %s", i, fmt(o), fmt(expv(2, 1'b0, 1'b1)));
         end
         @(negedge clk);
         m_commit(2, costs[i]);
         o = obs(2);
         n_cmp++;
         if (o !== expv(2, 1'b1, 1'b0)) begin
            n_bad++; $display("FAIL legacy_done[%0d] got %s want %s", i, fmt(o), fmt(expv(2, 1'b1, 1'b0)));
         end
         n_cmp++;
         if (o.min !== 10'(wmin[i]) || o.cnt !== 4'(wcnt[i]) || o.last !== 10'(costs[i])) begin
            n_bad++; $display("FAIL legacy_table[%0d] got min=%0d cnt=%0d last=%0d want %0d %0d %0d",
                              i, o.min, o.cnt, o.last, wmin[i], wcnt[i], costs[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int t[8], wmin[3], wcnt[3], wlast[3];
      int s, lat;
      obs_t oc[2], od[2];
      wmin  = '{120, 120, 112};
      wcnt  = '{1, 2, 1};
      wlast = '{120, 120, 112};
      for (int c = 0; c < 3; c++) begin
         case (c)
            0:       t = '{10, 20, 30, 40, 5, 5, 5, 5};
            1:       t = '{default: 15};
            default: t = '{default: 14};
         endcase
         cand8(t, 0, (c == 1), oc, od, lat);
         s = 0;
         for (int i = 0; i < 8; i++) s += t[i];
         for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (oc[k] !== expv(k, 1'b0, 1'b1)) begin
               n_bad++; $display("FAIL b2b_cmp[%0d][%0d] got %s want %s", c, k, fmt(oc[k]), fmt(expv(k, 1'b0, 1'b1)));
            end
            m_commit(k, s);
            n_cmp++;
            if (od[k] !== expv(k, 1'b1, 1'b0)) begin
               n_bad++; $display("FAIL b2b_done[%0d][%0d] got %s want %s", c, k, fmt(od[k]), fmt(expv(k, 1'b1, 1'b0)));
            end
         end
         n_cmp++;
         if (lat !== 1) begin
            n_bad++; $display("FAIL b2b_latency[%0d] got %0d want 1", c, lat);
         end
         n_cmp++;
         if (od[0].min !== 10'(wmin[c]) || od[0].cnt !== 4'(wcnt[c]) || od[0].last !== 10'(wlast[c])) begin
            n_bad++; $display("FAIL b2b_table[%0d] got min=%0d cnt=%0d last=%0d want %0d %0d %0d",
                              c, od[0].min, od[0].cnt, od[0].last, wmin[c], wcnt[c], wlast[c]);
         end
      end
      @(negedge clk);
      n_cmp++;
      if (b8.done !== 1'b0) begin
         n_bad++; $display("FAIL done_width got %0b want 0", b8.done);
      end
   endtask

   task automatic test_sum_sat();
      int t[8], lat;
      obs_t oc[2], od[2];
      clear8();
      t = '{default: 127};
      cand8(t, 1, 1'b0, oc, od, lat);
      for (int k = 0; k < 2; k++) begin
         m_commit(k, 1016);
         n_cmp++;
         if (od[k] !== expv(k, 1'b1, 1'b0)) begin
            n_bad++; $display("FAIL sumsat_done[%0d] got %s want %s", k, fmt(od[k]), fmt(expv(k, 1'b1, 1'b0)));
         end
      end
      n_cmp++;
      if (od[0].min !== 10'd1016 || od[0].sat !== 1'b0 || od[1].last !== 10'd511 || od[1].sat !== 1'b1) begin
         n_bad++; $display("FAIL sumsat_table got min10=%0d sat10=%0b last9=%0d sat9=%0b want 1016 0 511 1",
                           od[0].min, od[0].sat, od[1].last, od[1].sat);
      end
   endtask

   task automatic test_match_sat();
      obs_t o;
      t1_clear = 1'b1;
      @(negedge clk);
      t1_clear = 1'b0;
      m_reset(2);
      for (int i = 0; i < 20; i++) begin
         t1_start = 1'b1;
         t1_cost  = 7'd7;
         @(negedge clk);
         t1_start = 1'b0;
         @(negedge clk);
         m_commit(2, 7);
         o = obs(2);
         n_cmp++;
         if (o !== expv(2, 1'b1, 1'b0) || o.min !== 10'd7 || o.cnt !== 4'((i < 15) ? i + 1 : 15)) begin
            n_bad++; $display("FAIL matchsat[%0d] got %s want %s", i, fmt(o), fmt(expv(2, 1'b1, 1'b0)));
         end
      end
   endtask

   task automatic test_clear();
      int t[8], lat, dones;
      obs_t o, oc[2], od[2];
      for (int i = 0; i < 3; i++) begin
         t8_start = 1'b1;
         t8_cost  = 7'(i + 1);
         @(negedge clk);
      end
      t8_start = 1'b0;
      clear8();
      for (int k = 0; k < 2; k++) begin
         o = obs(k);
         n_cmp++;
         if (o !== expv(k, 1'b0, 1'b0)) begin
            n_bad++; $display("FAIL clear_mid[%0d] got %s want %s", k, fmt(o), fmt(expv(k, 1'b0, 1'b0)));
         end
      end
      dones = 0;
      repeat (12) begin
         @(negedge clk);
         if (b8.done || b9.done) dones++;
      end
      n_cmp++;
      if (dones !== 0) begin
         n_bad++; $display("FAIL clear_nodone got %0d pulses want 0", dones);
      end
      t = '{default: 10};
      cand8(t, 0, 1'b0, oc, od, lat);
      for (int k = 0; k < 2; k++) m_commit(k, 80);
      n_cmp++;
      if (od[0] !== expv(0, 1'b1, 1'b0) || od[0].min !== 10'd80 || od[0].cnt !== 4'd1 || lat !== 1) begin
         n_bad++; $display("FAIL clear_then_full got %s lat=%0d want %s lat=1", fmt(od[0]), lat, fmt(expv(0, 1'b1, 1'b0)));
      end
      // Restart while in CMP: the finished candidate must vanish without a done.
      for (int i = 0; i < 8; i++) begin
         t8_start = 1'b1;
         t8_cost  = 7'd3;
         @(negedge clk);
      end
      t8_start = 1'b0;
      clear8();
      for (int k = 0; k < 2; k++) begin
         o = obs(k);
         n_cmp++;
         if (o !== expv(k, 1'b0, 1'b0)) begin
            n_bad++; $display("FAIL clear_cmp[%0d] got %s want %s", k, fmt(o), fmt(expv(k, 1'b0, 1'b0)));
         end
      end
   endtask

   task automatic test_rst_in_cmp();
      obs_t o;
      for (int i = 0; i < 8; i++) begin
         t8_start = 1'b1;
         t8_cost  = 7'($urandom_range(0, 127));
         if (i == 7) begin
            t1_start = 1'b1;
            t1_cost  = 7'd5;
         end
         @(negedge clk);
      end
      t8_start = 1'b0;
      t1_start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         o = obs(k);
         n_cmp++;
         if (o !== expv(k, 1'b0, 1'b1)) begin
            n_bad++; $display("FAIL rst_precmp[%0d] got %s want %s", k, fmt(o), fmt(expv(k, 1'b0, 1'b1)));
         end
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         m_reset(k);
         o = obs(k);
         n_cmp++;
         if (o !== expv(k, 1'b0, 1'b0)) begin
            n_bad++; $display("FAIL rst_cmp[%0d] got %s want %s", k, fmt(o), fmt(expv(k, 1'b0, 1'b0)));
         end
      end
   endtask

   task automatic test_random();
      int t[8], s, lat, c;
      bit hold;
      obs_t o, oc[2], od[2];
      for (int n = 0; n < 25; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            clear8();
            o = obs(0);
            n_cmp++;
            if (o !== expv(0, 1'b0, 1'b0)) begin
               n_bad++; $display("FAIL rand_clear[%0d] got %s want %s", n, fmt(o), fmt(expv(0, 1'b0, 1'b0)));
            end
         end
         s = 0;
         c = $urandom_range(0, 3);
         for (int i = 0; i < 8; i++) begin
            t[i] = (c == 0) ? $urandom_range(0, 127) : $urandom_range(0, 2);
            s += t[i];
         end
         hold = 1'($urandom_range(0, 1));
         cand8(t, 2, hold, oc, od, lat);
         for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (oc[k] !== expv(k, 1'b0, 1'b1)) begin
               n_bad++; $display("FAIL rand_cmp[%0d][%0d] got %s want %s", n, k, fmt(oc[k]), fmt(expv(k, 1'b0, 1'b1)));
            end
            m_commit(k, s);
            n_cmp++;
            if (od[k] !== expv(k, 1'b1, 1'b0) || lat !== 1) begin
               n_bad++; $display("FAIL rand_done[%0d][%0d] got %s lat=%0d want %s lat=1", n, k, fmt(od[k]), lat, fmt(expv(k, 1'b1, 1'b0)));
            end
         end
      end
      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            t1_clear = 1'b1;
            @(negedge clk);
            t1_clear = 1'b0;
            m_reset(2);
         end
         c = $urandom_range(0, 8);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         t1_start = 1'b1;
         t1_cost  = 7'(c);
         @(negedge clk);
         t1_start = 1'b0;
         lat = 0;
         while (lat < 4) begin
            @(negedge clk);
            lat++;
            if (b1.done) break;
         end
         m_commit(2, c);
         o = obs(2);
         n_cmp++;
         if (o !== expv(2, 1'b1, 1'b0) || lat !== 1) begin
            n_bad++; $display("FAIL rand1[%0d] got %s lat=%0d want %s lat=1", n, fmt(o), lat, fmt(expv(2, 1'b1, 1'b0)));
         end
      end
   endtask

   initial begin
      rst      = 1'b1;
      t8_start = 1'b0; t8_clear = 1'b0; t8_cost = 7'd0;
      t1_start = 1'b0; t1_clear = 1'b0; t1_cost = 7'd0;
      test_reset();
      test_legacy();
      test_back_to_back();
      test_sum_sat();
      test_match_sat();
      test_clear();
      test_rst_in_cmp();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired before the sequence finished");
      $fatal(1, "watchdog");
   end

endmodule
